// File: rtl/io_input_unit.sv
// IN-instruction input unit: synchronizes and debounces the enter button, stalls the core,
// and captures the switch word. Define IO_INPUT_SIGNEXT_EN to sign-extend instead of zero-extend.
module io_input_unit #(
   parameter int SW_WIDTH        = 16,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                InReq,
   input  logic [SW_WIDTH-1:0] Switches,
   input  logic                EnterBtn,
   output logic [31:0]         DataIO,
   output logic                Stall,
   output logic                InDone
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_RELEASE,
      WAIT_PRESS,
      DONE
   } state_t;

   state_t              state;
   logic                btn_meta;
   logic                btn_s;
   logic                btn_d;
   logic [SW_WIDTH-1:0] sw_meta;
   logic [SW_WIDTH-1:0] sw_s;
   logic [CW-1:0]       db_cnt;
   logic                ext_fill;
   logic [31:0]         sw_ext;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         btn_meta <= 1'b0;
         btn_s    <= 1'b0;
         sw_meta  <= '0;
         sw_s     <= '0;
      end else begin
         btn_meta <= EnterBtn;
         btn_s    <= btn_meta;
         sw_meta  <= Switches;
         sw_s     <= sw_meta;
      end
   end

   // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         btn_d  <= 1'b0;
         db_cnt <= '0;
      end else if (btn_s != btn_d) begin
         if (db_cnt == CNT_MAX) begin
            btn_d  <= btn_s;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end else begin
         db_cnt <= '0;
      end
   end

`ifdef IO_INPUT_SIGNEXT_EN
   always_comb ext_fill = sw_s[SW_WIDTH-1];
`else
   always_comb ext_fill = 1'b0;
`endif

   always_comb begin
      sw_ext                 = {32{ext_fill}};
      sw_ext[SW_WIDTH-1:0]   = sw_s;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         DataIO <= '0;
         InDone <= 1'b0;
      end else begin
         InDone <= 1'b0;
         case (state)
            IDLE: begin
               // A button still held at entry must be released first.
               if (InReq) state <= btn_d ? WAIT_RELEASE : WAIT_PRESS;
            end
            WAIT_RELEASE: begin
               if (!InReq)      state <= IDLE;
               else if (!btn_d) state <= WAIT_PRESS;
            end
            WAIT_PRESS: begin
               if (!InReq) begin
                  state <= IDLE;
               end else if (btn_d) begin
                  DataIO <= sw_ext;
                  InDone <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Gated by reset_n so Stall drops immediately even if InReq is high during reset.
   always_comb begin
      Stall = reset_n && ((state == IDLE && InReq) ||
                          state == WAIT_RELEASE || state == WAIT_PRESS);
   end

endmodule

// File: tb/tb_io_input_unit.sv
// Self-checking bench for io_input_unit; reference model tracks the IN handshake at
// transaction level and derives debouncing from the history of synchronized button samples.
module tb_io_input_unit;

   localparam int SW_WIDTH = 16;
   localparam int DB       = 4;

   logic                clock    = 1'b0;
   logic                reset_n  = 1'b0;
   logic                InReq    = 1'b0;
   logic [SW_WIDTH-1:0] Switches = '0;
   logic                EnterBtn = 1'b0;
   logic [31:0]         DataIO;
   logic                Stall;
   logic                InDone;

   int unsigned checks = 0;
   int unsigned passes = 0;

   io_input_unit #(.SW_WIDTH(SW_WIDTH), .DEBOUNCE_CYCLES(DB)) dut (
      .clock(clock), .reset_n(reset_n), .InReq(InReq), .Switches(Switches),
      .EnterBtn(EnterBtn), .DataIO(DataIO), .Stall(Stall), .InDone(InDone)
   );

   always #5 clock = ~clock;

   // Reference model state
   bit          m_s1, m_s2;
   logic [15:0] m_w1, m_w2;
   bit          bs_hist[$];
   bit          m_btn_d;
   bit          m_waiting, m_need_rel, m_done;
   logic [31:0] m_data;

   function automatic logic [31:0] ext_word(input logic [15:0] v);
`ifdef IO_INPUT_SIGNEXT_EN
      return 32'($signed(v));
`else
      return {16'h0000, v};
`endif
   endfunction

   function automatic bit exp_stall();
      return reset_n && (m_waiting || (!m_done && InReq));
   endfunction

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_w1 = '0; m_w2 = '0;
      bs_hist.delete();
      m_btn_d = 0; m_waiting = 0; m_need_rel = 0; m_done = 0; m_data = '0;
   endtask

   task automatic model_edge();
      bit flip;
      if (!reset_n) begin
         model_reset();
         return;
      end
      if (m_done) m_done = 0;
      else if (!m_waiting) begin
         if (InReq) begin m_waiting = 1; m_need_rel = m_btn_d; end
      end
      else if (!InReq) m_waiting = 0;
      else if (m_need_rel) begin
         if (!m_btn_d) m_need_rel = 0;
      end
      else if (m_btn_d) begin
         m_data = ext_word(m_w2); m_waiting = 0; m_done = 1;
      end
      bs_hist.push_back(m_s2);
      if (bs_hist.size() > 32) void'(bs_hist.pop_front());
      if (bs_hist.size() >= DB) begin
         flip = 1;
         for (int i = 0; i < DB; i++)
            if (bs_hist[bs_hist.size() - 1 - i] == m_btn_d) flip = 0;
         if (flip) m_btn_d = !m_btn_d;
      end
      m_s2 = m_s1; m_s1 = EnterBtn;
      m_w2 = m_w1; m_w1 = Switches;
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset_n = 0; InReq = 1;
      repeat (3) tick();
      checks++; if (DataIO !== 32'h0) $display("FAIL reset_data: got %h want 00000000", DataIO); else passes++;
      checks++; if (Stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", Stall); else passes++;
      checks++; if (InDone !== 1'b0) $display("FAIL reset_indone: got %b want 0", InDone); else passes++;
      InReq = 0; reset_n = 1;
      tick();
   endtask

   task automatic test_basic();
      int unsigned edges = 0;
      bit done = 0;
      Switches = 16'h00A5; InReq = 1;
      repeat (4) begin
         tick();
         checks++;
         if ({DataIO, Stall, InDone} !== {m_data, exp_stall(), m_done})
            $display("FAIL basic_wait: got data=%h stall=%b done=%b want data=%h stall=%b done=%b",
                     DataIO, Stall, InDone, m_data, exp_stall(), m_done);
         else passes++;
      end
      EnterBtn = 1;
      while (!done && edges < 20) begin
         tick(); edges++;
         checks++;
         if ({DataIO, Stall, InDone} !== {m_data, exp_stall(), m_done})
            $display("FAIL basic_cycle: got data=%h stall=%b done=%b want data=%h stall=%b done=%b",
                     DataIO, Stall, InDone, m_data, exp_stall(), m_done);
         else passes++;
         if (InDone) done = 1;
      end
      checks++; if (edges != 7) $display("FAIL basic_latency: got %0d edges want 7", edges); else passes++;
      checks++; if (DataIO !== 32'h000000A5) $display("FAIL basic_data: got %h want 000000a5", DataIO); else passes++;
      checks++; if (Stall !== 1'b0) $display("FAIL basic_stall_done: got %b want 0", Stall); else passes++;
      InReq = 0;
      tick();
      checks++; if (InDone !== 1'b0) $display("FAIL basic_pulse_width: got %b want 0", InDone); else passes++;
      EnterBtn = 0;
      repeat (8) tick();
   endtask

   task automatic test_bounce();
      bit bad = 0;
      InReq = 1;
      for (int i = 0; i < 10; i++) begin
         EnterBtn = (i % 2 == 0);
         repeat (2) begin
            tick();
            if (InDone !== 1'b0 || Stall !== 1'b1) bad = 1;
         end
      end
      EnterBtn = 0;
      repeat (10) begin
         tick();
         if (InDone !== 1'b0 || Stall !== 1'b1) bad = 1;
         checks++;
         if ({DataIO, Stall, InDone} !== {m_data, exp_stall(), m_done})
            $display("FAIL bounce_cycle: got data=%h stall=%b done=%b want data=%h stall=%b done=%b",
                     DataIO, Stall, InDone, m_data, exp_stall(), m_done);
         else passes++;
      end
      checks++; if (bad) $display("FAIL bounce_reject: got capture/unstall want none"); else passes++;
      InReq = 0;
      tick();
      checks++; if (DataIO !== 32'h000000A5) $display("FAIL abort_keeps_data: got %h want 000000a5", DataIO); else passes++;
      checks++; if (Stall !== 1'b0) $display("FAIL abort_stall: got %b want 0", Stall); else passes++;
   endtask

   task automatic test_held();
      logic [15:0] sw;
      bit seen = 0;
      int unsigned n = 0;
      EnterBtn = 1;
      repeat (8) tick();
      sw = 16'($urandom); Switches = sw; InReq = 1;
      repeat (15) begin
         tick();
         if (InDone) seen = 1;
      end
      checks++; if (seen) $display("FAIL held_no_capture: got InDone want none"); else passes++;
      checks++; if (Stall !== 1'b1) $display("FAIL held_stall: got %b want 1", Stall); else passes++;
      EnterBtn = 0;
      repeat (8) tick();
      EnterBtn = 1;
      while (!seen && n < 20) begin
         tick(); n++;
         checks++;
         if ({DataIO, Stall, InDone} !== {m_data, exp_stall(), m_done})
            $display("FAIL held_cycle: got data=%h stall=%b done=%b want data=%h stall=%b done=%b",
                     DataIO, Stall, InDone, m_data, exp_stall(), m_done);
         else passes++;
         if (InDone) seen = 1;
      end
      checks++; if (!seen || DataIO !== ext_word(sw)) $display("FAIL held_capture: got %h want %h", DataIO, ext_word(sw)); else passes++;
      InReq = 0; EnterBtn = 0;
      repeat (8) tick();
   endtask

   task automatic test_back_to_back();
      bit seen = 0;
      int unsigned n = 0;
      Switches = 16'h0001; InReq = 1;
      repeat (3) tick();
      EnterBtn = 1;
      while (!seen && n < 20) begin tick(); n++; if (InDone) seen = 1; end
      checks++; if (!seen || DataIO !== 32'h1) $display("FAIL b2b_first: got %h want 00000001", DataIO); else passes++;
      Switches = 16'h0002; seen = 0;
      repeat (15) begin
         tick();
         if (InDone) seen = 1;
         checks++;
         if ({DataIO, Stall, InDone} !== {m_data, exp_stall(), m_done})
            $display("FAIL b2b_hold: got data=%h stall=%b done=%b want data=%h stall=%b done=%b",
                     DataIO, Stall, InDone, m_data, exp_stall(), m_done);
         else passes++;
      end
      checks++; if (seen || Stall !== 1'b1) $display("FAIL b2b_second_stalls: got done=%b stall=%b want 0/1", seen, Stall); else passes++;
      EnterBtn = 0;
      repeat (8) tick();
      EnterBtn = 1; n = 0;
      while (!seen && n < 20) begin tick(); n++; if (InDone) seen = 1; end
      checks++; if (!seen || DataIO !== 32'h2) $display("FAIL b2b_second: got %h want 00000002", DataIO); else passes++;
      InReq = 0; EnterBtn = 0;
      repeat (8) tick();
   endtask

   task automatic test_extension();
      bit seen = 0;
      int unsigned n = 0;
      logic [31:0] want;
`ifdef IO_INPUT_SIGNEXT_EN
      want = 32'hFFFF8001;
`else
      want = 32'h00008001;
`endif
      Switches = 16'h8001; InReq = 1;
      repeat (3) tick();
      EnterBtn = 1;
      while (!seen && n < 20) begin tick(); n++; if (InDone) seen = 1; end
      checks++; if (!seen || DataIO !== want) $display("FAIL extension: got %h want %h", DataIO, want); else passes++;
      InReq = 0; EnterBtn = 0;
      repeat (8) tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(7) == 0) InReq = !InReq;
         if (InDone && $urandom_range(1) == 0) InReq = 0;
         if ($urandom_range(3) == 0) Switches = 16'($urandom);
         if ($urandom_range(5) == 0) EnterBtn = !EnterBtn;
         tick();
         checks++;
         if ({DataIO, Stall, InDone} !== {m_data, exp_stall(), m_done})
            $display("FAIL random_cycle%0d: got data=%h stall=%b done=%b want data=%h stall=%b done=%b",
                     i, DataIO, Stall, InDone, m_data, exp_stall(), m_done);
         else passes++;
      end
      InReq = 0; EnterBtn = 0;
      repeat (8) tick();
   endtask

   task automatic test_reset_mid();
      bit seen = 0;
      int unsigned n = 0;
      Switches = 16'h1234; InReq = 1;
      repeat (3) tick();
      EnterBtn = 1;
      while (!seen && n < 20) begin tick(); n++; if (InDone) seen = 1; end
      checks++; if (!seen || DataIO !== 32'h1234) $display("FAIL rst_setup: got %h want 00001234", DataIO); else passes++;
      InReq = 0; EnterBtn = 0;
      repeat (8) tick();
      InReq = 1;
      repeat (3) tick();
      checks++; if (Stall !== 1'b1) $display("FAIL rst_pre_stall: got %b want 1", Stall); else passes++;
      #2 reset_n = 0;
      #1;
      checks++; if (DataIO !== 32'h0) $display("FAIL rst_async_data: got %h want 00000000", DataIO); else passes++;
      checks++; if (Stall !== 1'b0) $display("FAIL rst_async_stall: got %b want 0", Stall); else passes++;
      checks++; if (InDone !== 1'b0) $display("FAIL rst_async_indone: got %b want 0", InDone); else passes++;
      model_reset();
      tick();
      InReq = 0; reset_n = 1;
      tick();
      checks++; if (Stall !== 1'b0 || DataIO !== 32'h0) $display("FAIL rst_idle: got stall=%b data=%h want 0/0", Stall, DataIO); else passes++;
      InReq = 1;
      repeat (3) begin
         tick();
         checks++;
         if ({DataIO, Stall, InDone} !== {m_data, exp_stall(), m_done})
            $display("FAIL rst_after: got data=%h stall=%b done=%b want data=%h stall=%b done=%b",
                     DataIO, Stall, InDone, m_data, exp_stall(), m_done);
         else passes++;
      end
      InReq = 0;
      tick();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_bounce();
      test_held();
      test_back_to_back();
      test_extension();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
